// File: rtl/mux_arb_pkg.sv
// Shared types and reset constants for the two-requester mux arbiter.
// Provides the output FSM state enum and the tie-break grant helper.
package mux_arb_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } arb_state_e;

  localparam logic Y_RST_BIT = 1'b0;
  localparam logic SRC_RST   = 1'b0;
  localparam logic PRIO_RST  = 1'b0;

  // Lone requester wins; on a tie the pointer decides.
  // With nobody valid the select parks on the pointer.
  function automatic logic arb_grant(
    input logic v0,
    input logic v1,
    input logic prio
  );
    logic g;
    g = prio;
    if (v0 && v1) g = prio;
    else if (v1)  g = 1'b1;
    else if (v0)  g = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/mux_2.sv
// Two-input word multiplexer shared by the arbiter datapath.
// Ports: i_d0/i_d1 data, i_s select (1 picks i_d1), o_y result.
module mux_2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_s,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_s ? i_d1 : i_d0;

endmodule

// File: rtl/mux_2_arbiter.sv
// Two-requester valid/ready arbiter feeding one registered output slot.
// Ports: i_clk, i_reset (sync, high); req K: i_dK, i_validK, o_readyK;
// out: o_y, o_valid, i_ready, o_src; o_sel is the live mux select.
// Build option: ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module mux_2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d0,
  input  logic             i_valid0,
  output logic             o_ready0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_valid1,
  output logic             o_ready1,
  output logic [WIDTH-1:0] o_y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_src,
  output logic             o_sel
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             src_q;
  logic             src_d;
  logic [WIDTH-1:0] mux_y;
  logic             prio;
  logic             grant;
  logic             can_accept;
  logic             acc0;
  logic             acc1;
  logic             accept;

`ifdef ARB_FIXED_PRIO_EN
  assign prio = PRIO_RST;
`else
  logic prio_q;
  logic prio_d;

  // Loser of the last transfer is favoured next.
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~grant;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) prio_q <= PRIO_RST;
    else         prio_q <= prio_d;
  end

  assign prio = prio_q;
`endif

  always_comb begin
    grant      = arb_grant(i_valid0, i_valid1, prio);
    can_accept = (state_q == S_EMPTY) || i_ready;
    // Reset cycle must never handshake a word.
    acc0   = !i_reset && can_accept && !grant && i_valid0;
    acc1   = !i_reset && can_accept &&  grant && i_valid1;
    accept = acc0 || acc1;
  end

  mux_2 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_d0 (i_d0),
    .i_d1 (i_d1),
    .i_s  (grant),
    .o_y  (mux_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL: begin
        if (!accept && i_ready) state_d = S_EMPTY;
      end
    endcase
  end

  always_comb begin
    o_valid = (state_q == S_FULL);
  end

  always_comb begin
    y_d   = y_q;
    src_d = src_q;
    if (accept) begin
      y_d   = mux_y;
      src_d = grant;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      y_q   <= {WIDTH{Y_RST_BIT}};
      src_q <= SRC_RST;
    end else begin
      y_q   <= y_d;
      src_q <= src_d;
    end
  end

  assign o_ready0 = acc0;
  assign o_ready1 = acc1;
  assign o_y      = y_q;
  assign o_src    = src_q;
  assign o_sel    = grant;

endmodule

// File: tb/tb_mux_2_arbiter.sv
// Self-checking bench for mux_2_arbiter: directed table plus
// randomized traffic against a one-slot behavioural model.
module tb_mux_2_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] d0;
  logic       v0;
  logic       r0;
  logic [7:0] d1;
  logic       v1;
  logic       r1;
  logic [7:0] y;
  logic       vo;
  logic       rdy;
  logic       src;
  logic       sel;

  int n_vec;
  int n_err;

  mux_2_arbiter #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_d0     (d0),
    .i_valid0 (v0),
    .o_ready0 (r0),
    .i_d1     (d1),
    .i_valid1 (v1),
    .o_ready1 (r1),
    .o_y      (y),
    .o_valid  (vo),
    .i_ready  (rdy),
    .o_src    (src),
    .o_sel    (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       rdy;
    logic       ev;
    logic [7:0] ey;
    logic       es;
    logic       er0;
    logic       er1;
  } vec_t;

  vec_t tbl[26];

  // Model: occupancy of the single output slot, last word/source
  // shown, and which requester a tie currently favours.
  int         m_occ;
  logic [7:0] m_y;
  logic       m_src;
  logic       m_fav;

  function automatic vec_t mk(
    input logic rs, input logic a0, input logic [7:0] b0,
    input logic a1, input logic [7:0] b1, input logic rd,
    input logic ev, input logic [7:0] ey, input logic es,
    input logic e0, input logic e1);
    vec_t t;
    t.rst = rs; t.v0 = a0; t.d0 = b0; t.v1 = a1; t.d1 = b1;
    t.rdy = rd; t.ev = ev; t.ey = ey; t.es = es;
    t.er0 = e0; t.er1 = e1;
    return t;
  endfunction

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int winner();
    if (v0 && v1) return FIX ? 0 : int'(m_fav);
    if (v1) return 1;
    if (v0) return 0;
    return -1;
  endfunction

  task automatic drive(input logic rs, input logic a0,
                       input logic [7:0] b0, input logic a1,
                       input logic [7:0] b1, input logic rd);
    @(negedge clk);
    rst = rs; v0 = a0; d0 = b0; v1 = a1; d1 = b1; rdy = rd;
    #1;
  endtask

  task automatic check_model();
    int  w;
    bit  room;
    w    = winner();
    room = (m_occ == 0) || rdy;
    check("m_valid", {7'd0, vo}, {7'd0, m_occ != 0});
    check("m_y", y, m_y);
    check("m_src", {7'd0, src}, {7'd0, m_src});
    check("m_ready0", {7'd0, r0},
          {7'd0, !rst && room && w == 0});
    check("m_ready1", {7'd0, r1},
          {7'd0, !rst && room && w == 1});
    check("m_sel", {7'd0, sel},
          {7'd0, (w < 0) ? (FIX ? 1'b0 : m_fav) : w[0]});
  endtask

  task automatic step();
    int w;
    bit room;
    w    = winner();
    room = (m_occ == 0) || rdy;
    @(posedge clk);
    if (rst) begin
      m_occ = 0; m_y = 8'h00; m_src = 1'b0; m_fav = 1'b0;
    end else begin
      if (m_occ != 0 && rdy) m_occ = 0;
      if (w >= 0 && room) begin
        m_occ = 1;
        m_y   = (w == 1) ? d1 : d0;
        m_src = w[0];
        m_fav = ~w[0];
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; rdy = 1'b0;
    m_occ = 0; m_y = 8'h00; m_src = 1'b0; m_fav = 1'b0;
    repeat (2) @(posedge clk);

    tbl[0]  = mk(1,1,8'h55,1,8'h66,1, 0,8'h00,0,0,0);
    tbl[1]  = mk(1,1,8'h55,1,8'h66,1, 0,8'h00,0,0,0);
    tbl[2]  = mk(1,1,8'h55,1,8'h66,1, 0,8'h00,0,0,0);
    tbl[3]  = mk(0,1,8'h11,1,8'h22,1, 0,8'h00,0,1,0);
    tbl[4]  = mk(0,1,8'h11,1,8'h22,1, 1,8'h11,0,1,!FIX);
    tbl[4].er0 = FIX;
    tbl[5]  = mk(0,1,8'h11,1,8'h22,1, 1,FIX?8'h11:8'h22,!FIX,1,0);
    tbl[6]  = mk(0,1,8'h11,1,8'h22,1, 1,8'h11,0,FIX,!FIX);
    tbl[7]  = mk(0,0,8'h00,0,8'h00,1, 1,FIX?8'h11:8'h22,!FIX,0,0);
    tbl[8]  = mk(0,0,8'h00,1,8'hA5,1, 0,FIX?8'h11:8'h22,!FIX,0,1);
    tbl[9]  = mk(0,0,8'h00,0,8'h00,1, 1,8'hA5,1,0,0);
    tbl[10] = mk(0,0,8'h00,0,8'h00,1, 0,8'hA5,1,0,0);
    tbl[11] = mk(0,1,8'h33,0,8'h00,0, 0,8'hA5,1,1,0);
    for (int i = 12; i < 17; i++)
      tbl[i] = mk(0,0,8'h00,1,8'h77,0, 1,8'h33,0,0,0);
    tbl[17] = mk(0,0,8'h00,1,8'h77,1, 1,8'h33,0,0,1);
    tbl[18] = mk(0,1,8'h44,0,8'h00,1, 1,8'h77,1,1,0);
    tbl[19] = mk(1,1,8'h88,1,8'h99,0, 1,8'h44,0,0,0);
    tbl[20] = mk(0,0,8'h00,0,8'h00,0, 0,8'h00,0,0,0);
    tbl[21] = mk(0,0,8'h00,1,8'h12,0, 0,8'h00,0,0,1);
    tbl[22] = mk(0,1,8'h34,0,8'h00,0, 1,8'h12,1,0,0);
    tbl[23] = mk(0,0,8'h00,0,8'h00,1, 1,8'h12,1,0,0);
    tbl[24] = mk(0,1,8'h56,1,8'h78,1, 0,8'h12,1,1,0);
    tbl[25] = mk(0,0,8'h00,0,8'h00,1, 1,8'h56,0,0,0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].d0,
            tbl[i].v1, tbl[i].d1, tbl[i].rdy);
      check($sformatf("t%0d_valid", i), {7'd0, vo}, {7'd0, tbl[i].ev});
      check($sformatf("t%0d_y", i), y, tbl[i].ey);
      check($sformatf("t%0d_src", i), {7'd0, src}, {7'd0, tbl[i].es});
      check($sformatf("t%0d_ready0", i), {7'd0, r0}, {7'd0, tbl[i].er0});
      check($sformatf("t%0d_ready1", i), {7'd0, r1}, {7'd0, tbl[i].er1});
      check_model();
      step();
    end

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 3) != 0);
      check_model();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
